// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command front end.
//   - DATA_W_DEF : default SPI byte width
//   - ST_* / *_BASE : status and command byte values exchanged with the MBED
//   - spi_state_e : frame state encoding used by spi_cmd_slave
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    // Status bytes returned to the MBED
    localparam logic [7:0] ST_IDLE    = 8'd20;
    localparam logic [7:0] ST_GO_ACK  = 8'd21;

    // Command byte ranges decoded by the interpreter
    localparam logic [7:0] LED_BASE   = 8'd32;
    localparam logic [7:0] SERVO_BASE = 8'd64;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/sig_sync.sv
// Multi-flop synchroniser for one asynchronous input.
//   clk, rst_n : destination clock and async active-low reset
//   d          : raw asynchronous input
//   q          : synchronised output (STAGES clk cycles of delay)
// RST_VAL sets the chain contents in reset so an inactive line does not
// produce a spurious edge when reset releases.
module sig_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave feeding the command interpreter.
//   clk, rst_n        : 50 MHz system clock, async active-low reset
//   sclk, ss_n, mosi  : raw SPI pins from the MBED (asynchronous)
//   miso, miso_oe     : slave data out and its output enable
//   rx_data, rx_valid : last received byte, held until rx_ack
//   rx_ack            : consumer acknowledge pulse
//   tx_data, tx_load  : reply byte staged for the next SPI byte
//   frame_err         : pulse when SS is released mid-byte
//   overrun, ovr_clr  : sticky lost-byte flag and its clear
// All SPI lines are oversampled in the clk domain; SCLK must be at most
// clk/8 so every SCLK edge is seen and MISO settles before the master
// samples it.
module spi_cmd_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(ST_IDLE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // ------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------
    logic sclk_s, ss_s, mosi_s;
    logic sclk_d, ss_d;

    sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
    );
    sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_s)
    );
    sig_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign ss_fall   = ~ss_s   &  ss_d;
    assign ss_rise   =  ss_s   & ~ss_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    spi_state_e state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic byte_done;
    logic do_start, do_shift_in, do_shift_out, do_complete, do_abort;
    logic frame_err_nxt;

    assign byte_done = (bit_cnt == CNT_W'(DATA_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        do_start      = 1'b0;
        do_shift_in   = 1'b0;
        do_shift_out  = 1'b0;
        do_complete   = 1'b0;
        do_abort      = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    do_start  = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                // Completion takes a cycle of its own after the 8th rise;
                // the SCLK rate limit guarantees no SCLK edge lands here.
                if (byte_done) begin
                    do_complete = 1'b1;
                end else begin
                    do_shift_in  = sclk_rise;
                    do_shift_out = sclk_fall;
                end
                if (ss_rise) begin
                    do_abort      = 1'b1;
                    frame_err_nxt = (bit_cnt != '0) && !byte_done;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Reply staging
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_stage, tx_sel;
    logic              tx_pending;
    logic              reload;

    assign tx_sel = tx_pending ? tx_stage : TX_IDLE;
    assign reload = do_start | do_complete;

    // A tx_load coinciding with a reload wins the pending flag, so the new
    // byte waits for the following reload while this one uses the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_stage   <= TX_IDLE;
            tx_pending <= 1'b0;
        end else if (tx_load) begin
            tx_stage   <= tx_data;
            tx_pending <= 1'b1;
        end else if (reload) begin
            tx_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Shift datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_sh, tx_sh;

    // tx_sh holds the bits still to be presented; miso is registered so it
    // only changes on a detected SCLK fall. At frame start the MSB goes out
    // immediately, so tx_sh is loaded pre-shifted. On a byte reload it is
    // loaded unshifted and the next fall presents the new MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh   <= '0;
            tx_sh   <= '0;
            bit_cnt <= '0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            rx_data <= '0;
        end else begin
            if (do_start) begin
                tx_sh   <= tx_sel << 1;
                miso    <= tx_sel[DATA_W-1];
                miso_oe <= 1'b1;
                bit_cnt <= '0;
            end
            if (do_shift_in) begin
                rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_shift_out) begin
                miso  <= tx_sh[DATA_W-1];
                tx_sh <= tx_sh << 1;
            end
            if (do_complete) begin
                rx_data <= rx_sh;
                tx_sh   <= tx_sel;
                bit_cnt <= '0;
            end
            if (do_abort) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                bit_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Consumer handshake and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_nxt;

            if (do_complete)  rx_valid <= 1'b1;
            else if (rx_ack)  rx_valid <= 1'b0;

            // A same-cycle ack frees the slot, so that byte is not lost.
            if (do_complete && rx_valid && !rx_ack) overrun <= 1'b1;
            else if (ovr_clr)                        overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_slave.sv
module tb_spi_cmd_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       frame_err, overrun;
    logic       ovr_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    spi_cmd_slave dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .tx_data(tx_data), .tx_load(tx_load),
        .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #10 clk = ~clk;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: a new byte is presented when rx_valid rises or
    // the held data changes while valid.
    initial begin
        logic       prev_v;
        logic [7:0] prev_d;
        logic [7:0] e;
        prev_v = 1'b0;
        prev_d = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rx_valid && (!prev_v || rx_data != prev_d)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rx: got %02h expected none", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_data", rx_data, e);
                    end
                end
                if (frame_err) fe_cnt++;
            end
            prev_v = rx_valid;
            prev_d = rx_data;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic stage(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame_begin();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master, SCLK half period = 4 clk (clk/8). MISO is checked at
    // the rising (sample) edge and again just before the fall.
    task automatic spi_xfer(input logic [7:0] tx, input logic [7:0] exp_miso,
                            input int nbits, input bit lat, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            #1 chk("miso_at_rise", {7'd0, miso}, {7'd0, exp_miso[7-i]});
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == nbits - 1) begin
                    if (lat && k == 3) chk("latency_before", {7'd0, rx_valid}, 8'd0);
                    if (lat && k == 4) chk("latency_at", {7'd0, rx_valid}, 8'd1);
                    if (ack_last) rx_ack = (k == 3);
                end
                if (k == 4) chk("miso_hold", {7'd0, miso}, {7'd0, exp_miso[7-i]});
            end
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] tx, input logic [7:0] exp_miso,
                             input bit lat, input bit ack_last);
        exp_q.push_back(tx);
        spi_xfer(tx, exp_miso, 8, lat, ack_last);
    endtask

    initial begin
        int fe0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_miso", {7'd0, miso}, 8'd0);
        chk("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
        chk("rst_rx_data", rx_data, 8'd0);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
        chk("rst_frame_err", {7'd0, frame_err}, 8'd0);
        chk("rst_overrun", {7'd0, overrun}, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-frame at bit 4
        stage(8'hFF);
        frame_begin();
        spi_xfer(8'hF0, 8'hFF, 4, 1'b0, 1'b0);
        chk("midframe_oe", {7'd0, miso_oe}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_miso", {7'd0, miso}, 8'd0);
        chk("async_rst_oe", {7'd0, miso_oe}, 8'd0);
        chk("async_rst_valid", {7'd0, rx_valid}, 8'd0);
        chk("async_rst_data", rx_data, 8'd0);
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fe0 = fe_cnt;
        frame_begin();
        send_byte(8'h01, 8'h14, 1'b0, 1'b0);
        frame_end();
        chk("post_rst_valid", {7'd0, rx_valid}, 8'd1);
        chk("post_rst_no_fe", 8'(fe_cnt - fe0), 8'd0);
        pulse_ack();
        @(negedge clk);
        chk("ack_clears_valid", {7'd0, rx_valid}, 8'd0);

        // Single byte with latency check, idle reply
        frame_begin();
        send_byte(8'hA5, 8'h14, 1'b1, 1'b0);
        frame_end();
        pulse_ack();

        // Reply path, then idle again, then last-wins staging
        stage(8'h15);
        frame_begin();
        send_byte(8'h01, 8'h15, 1'b0, 1'b0);
        frame_end();
        pulse_ack();
        frame_begin();
        send_byte(8'h02, 8'h14, 1'b0, 1'b0);
        frame_end();
        pulse_ack();
        stage(8'h40);
        stage(8'h41);
        frame_begin();
        send_byte(8'h03, 8'h41, 1'b0, 1'b0);
        frame_end();
        pulse_ack();

        // Multi-byte frame with overrun
        frame_begin();
        send_byte(8'h11, 8'h14, 1'b0, 1'b0);
        send_byte(8'h22, 8'h14, 1'b0, 1'b0);
        frame_end();
        chk("overrun_set", {7'd0, overrun}, 8'd1);
        chk("overrun_valid", {7'd0, rx_valid}, 8'd1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", {7'd0, overrun}, 8'd0);
        frame_begin();
        send_byte(8'h33, 8'h14, 1'b0, 1'b1);
        frame_end();
        chk("ack_on_complete_no_ovr", {7'd0, overrun}, 8'd0);
        chk("ack_on_complete_valid", {7'd0, rx_valid}, 8'd1);
        pulse_ack();

        // Frame error: SS released after 5 bits
        frame_begin();
        send_byte(8'h5A, 8'h14, 1'b0, 1'b0);
        frame_end();
        fe0 = fe_cnt;
        frame_begin();
        spi_xfer(8'hFF, 8'h14, 5, 1'b0, 1'b0);
        frame_end();
        chk("frame_err_once", 8'(fe_cnt - fe0), 8'd1);
        chk("fe_rx_data_held", rx_data, 8'h5A);
        chk("fe_rx_valid_held", {7'd0, rx_valid}, 8'd1);
        chk("fe_miso_oe", {7'd0, miso_oe}, 8'd0);
        chk("fe_miso", {7'd0, miso}, 8'd0);
        pulse_ack();

        // clk/8 boundary patterns, staging across byte reloads
        stage(8'hC3);
        frame_begin();
        send_byte(8'h00, 8'hC3, 1'b0, 1'b0);
        stage(8'h3C);
        pulse_ack();
        send_byte(8'hFF, 8'h14, 1'b0, 1'b0);
        pulse_ack();
        send_byte(8'h80, 8'h3C, 1'b0, 1'b0);
        pulse_ack();
        frame_end();
        chk("boundary_no_ovr", {7'd0, overrun}, 8'd0);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
